// File: rtl/hybrid_run_ctrl.sv
// -----------------------------------------------------------------------------
// hybrid_run_ctrl
//
// Run controller for a decimating filter. It generates the downsampled-stage
// strobe (one pulse every DSR fast clocks), discards the first WARMUP strobes
// while the filter pipeline fills, then buffers each filter result in a small
// FIFO for a valid/ready consumer. A stop request in RUN lets the FIFO drain
// before the controller returns to IDLE.
//
// Optional feature:
//   HYBRID_RUN_CTRL_OVFCNT_EN  defined   -> ovf_count counts dropped samples
//                                           (saturating at 255)
//                              undefined -> ovf_count tied to 0
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   run request (IDLE only)
//   stop       in   halt request (WARMUP/RUN only)
//   ds_strobe  out  one-cycle pulse for the filter's downsampled stage
//   sample_in  in   filter result, valid in the ds_strobe cycle
//   out_data   out  FIFO head
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer accept (pop on out_valid && out_ready)
//   busy       out  controller not in IDLE
//   overflow   out  sticky: a RUN sample was dropped since the last start
//   ovf_count  out  dropped-sample count
// -----------------------------------------------------------------------------
module hybrid_run_ctrl #(
    parameter int DSR        = 12,
    parameter int WARMUP     = 8,
    parameter int OUT_WIDTH  = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    output logic                 ds_strobe,
    input  logic [OUT_WIDTH-1:0] sample_in,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 overflow,
    output logic [7:0]           ovf_count
);

    localparam int CW = $clog2(DSR);
    localparam int WW = $clog2(WARMUP + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    localparam logic [CW-1:0] DIV_LAST  = CW'(DSR - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
    localparam logic [OW-1:0] FULL_CNT  = OW'(FIFO_DEPTH);
    localparam logic [OW-1:0] EMPTY_CNT = OW'(0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          div_q, div_d, div_nx_s;
    logic [WW-1:0]          warm_q, warm_d;
    logic [OUT_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_q, rd_q;
    logic [OW-1:0]          cnt_q, cnt_d;
    logic                   strobe_q, strobe_d;
    logic                   valid_q;
    logic                   busy_q;
    logic                   ovf_q, ovf_d;
    logic                   pop_s, push_s, accept_s, drop_s;

    // Next-state, divider, warmup and FIFO bookkeeping
    always_comb begin
        // strobe_q is the registered "divider == DSR-1 in WARMUP/RUN" condition,
        // so it marks the current strobe cycle without re-decoding the counter.
        pop_s    = (cnt_q != EMPTY_CNT) && out_ready;
        push_s   = strobe_q && (state_q == S_RUN);
        // A full FIFO still accepts when the head leaves in the same cycle.
        accept_s = push_s && ((cnt_q != FULL_CNT) || pop_s);
        drop_s   = push_s && !accept_s;
        cnt_d    = cnt_q + OW'(accept_s) - OW'(pop_s);

        if (div_q == DIV_LAST) begin
            div_nx_s = CW'(0);
        end else begin
            div_nx_s = div_q + CW'(1);
        end

        state_d = state_q;
        div_d   = div_q;
        warm_d  = warm_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                div_d  = CW'(0);
                warm_d = WW'(0);
                if (start) begin
                    state_d = S_WARMUP;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WARMUP: begin
                if (stop) begin
                    state_d = S_IDLE;
                    div_d   = CW'(0);
                    warm_d  = WW'(0);
                end else begin
                    // The divider keeps running across WARMUP->RUN so the
                    // strobe spacing stays exactly DSR.
                    div_d = div_nx_s;
                    if (strobe_q) begin
                        if (warm_q == WARM_LAST) begin
                            state_d = S_RUN;
                            warm_d  = WW'(0);
                        end else begin
                            warm_d = warm_q + WW'(1);
                        end
                    end else begin
                        warm_d = warm_q;
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_DRAIN;
                    div_d   = CW'(0);
                end else begin
                    div_d = div_nx_s;
                end
                if (drop_s) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
            end
            S_DRAIN: begin
                div_d = CW'(0);
                // Leave as soon as the FIFO is empty after this cycle's pop.
                if (cnt_d == EMPTY_CNT) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = CW'(0);
                warm_d  = WW'(0);
            end
        endcase

        strobe_d = ((state_d == S_WARMUP) || (state_d == S_RUN)) && (div_d == DIV_LAST);
    end

    // Controller state, registered outputs and FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            div_q    <= CW'(0);
            warm_q   <= WW'(0);
            wr_q     <= AW'(0);
            rd_q     <= AW'(0);
            cnt_q    <= EMPTY_CNT;
            strobe_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= OUT_WIDTH'(0);
            end
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            warm_q   <= warm_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            valid_q  <= (cnt_d != EMPTY_CNT);
            busy_q   <= (state_d != S_IDLE);
            ovf_q    <= ovf_d;
            if (accept_s) begin
                mem_q[wr_q] <= sample_in;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_s) begin
                rd_q <= rd_q + AW'(1);
            end
        end
    end

    assign ds_strobe = strobe_q;
    assign out_valid = valid_q;
    assign out_data  = mem_q[rd_q];
    assign busy      = busy_q;
    assign overflow  = ovf_q;

`ifdef HYBRID_RUN_CTRL_OVFCNT_EN
    logic [7:0] ovfc_q;
    logic       ovfc_clr_s;

    assign ovfc_clr_s = (state_q == S_IDLE) && start;

    // Saturating dropped-sample counter, cleared when a new run starts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovfc_q <= 8'd0;
        end else if (ovfc_clr_s) begin
            ovfc_q <= 8'd0;
        end else if (drop_s && (ovfc_q != 8'hFF)) begin
            ovfc_q <= ovfc_q + 8'd1;
        end else begin
            ovfc_q <= ovfc_q;
        end
    end

    assign ovf_count = ovfc_q;
`else
    assign ovf_count = 8'd0;
`endif

endmodule

// File: tb/tb_hybrid_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hybrid_run_ctrl
//
// Directed plus random stimulus for hybrid_run_ctrl. A reference model tracks
// the controller as a phase, a cycle count since entering warmup (strobe when
// it is a multiple of DSR) and a queue for the output buffer; every cycle the
// DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_hybrid_run_ctrl;

    localparam int DSR    = 12;
    localparam int WARMUP = 8;
    localparam int OW     = 14;
    localparam int DEPTH  = 4;

`ifdef HYBRID_RUN_CTRL_OVFCNT_EN
    localparam int OVFC_EXP = 2;
`else
    localparam int OVFC_EXP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          ds_strobe;
    logic [OW-1:0] sample_in = '0;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          overflow;
    logic [7:0]    ovf_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit idx_mode = 1'b0;

    // reference model: 0 idle, 1 warmup, 2 run, 3 drain
    int            m_phase = 0;
    int            m_tick  = 0;
    int            m_nwarm = 0;
    int            m_sidx  = 0;
    bit            m_ovf   = 1'b0;
    int            m_ovfc  = 0;
    logic [OW-1:0] m_q[$];

    hybrid_run_ctrl #(
        .DSR(DSR), .WARMUP(WARMUP), .OUT_WIDTH(OW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .ds_strobe(ds_strobe), .sample_in(sample_in), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .overflow(overflow), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_strobe();
        return ((m_phase == 1) || (m_phase == 2)) && (m_tick % DSR == 0);
    endfunction

    task automatic cmp_all();
        chk("ds_strobe", ds_strobe, m_strobe());
        chk("busy", busy, m_phase != 0);
        chk("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
        chk("overflow", overflow, m_ovf);
        chk("ovf_count", ovf_count, m_ovfc);
    endtask

    // Advance model and DUT by one clock, then compare away from the edge.
    task automatic step();
        bit st, pop, full_before;
        if (idx_mode) sample_in = OW'(m_sidx + 1);
        st          = m_strobe();
        pop         = (m_q.size() != 0) && out_ready;
        full_before = (m_q.size() == DEPTH);
        if (pop) void'(m_q.pop_front());
        if (st && m_phase == 2) begin
            if (!full_before || pop) begin
                m_q.push_back(sample_in);
            end else begin
                m_ovf = 1'b1;
`ifdef HYBRID_RUN_CTRL_OVFCNT_EN
                if (m_ovfc < 255) m_ovfc++;
`endif
            end
        end
        if (st) m_sidx++;
        case (m_phase)
            0: if (start) begin
                m_phase = 1; m_tick = 1; m_nwarm = 0; m_sidx = 0; m_ovf = 1'b0; m_ovfc = 0;
            end
            1: if (stop) m_phase = 0;
               else begin
                   if (st) begin
                       m_nwarm++;
                       if (m_nwarm == WARMUP) m_phase = 2;
                   end
                   m_tick++;
               end
            2: if (stop) m_phase = 3; else m_tick++;
            3: if (m_q.size() == 0) m_phase = 0;
            default: m_phase = 0;
        endcase
        @(posedge clk);
        cyc++;
        #1;
        cmp_all();
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ds_strobe", ds_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_ovf_count", ovf_count, 0);
        m_phase = 0; m_tick = 0; m_nwarm = 0; m_sidx = 0; m_ovf = 1'b0; m_ovfc = 0;
        m_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Start a run with out_ready=1 and indexed samples; check headline timing.
    task automatic measure_start(input string tag);
        int first_s, first_v, nv;
        logic [OW-1:0] d[3];
        first_s = -1; first_v = -1; nv = 0;
        idx_mode = 1'b1; out_ready = 1'b1;
        start = 1'b1; cyc = 0;
        step();
        start = 1'b0;
        for (int i = 0; i < 140; i++) begin
            if (ds_strobe && first_s < 0) first_s = cyc;
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (nv < 3) d[nv] = out_data;
                nv++;
            end
            step();
        end
        chk({tag, "_first_strobe"}, first_s, 12);
        chk({tag, "_first_valid"}, first_v, 109);
        chk({tag, "_nvalid"}, nv, 3);
        chk({tag, "_data0"}, d[0], 9);
        chk({tag, "_data1"}, d[1], 10);
        chk({tag, "_data2"}, d[2], 11);
        chk({tag, "_no_overflow"}, overflow, 0);
    endtask

    initial begin
        int g, n, nv, ns, np;
        rst = 1'b1;
        #1;
        do_reset();

        // Headline timing and in-order delivery
        measure_start("run1");

        // Let the buffer empty, then hold the consumer off for 6 strobes
        g = 0;
        while (m_q.size() != 0 && g < 50) begin step(); g++; end
        out_ready = 1'b0;
        n = 0; g = 0;
        while (n < 6 && g < 200) begin
            if (m_strobe()) n++;
            step(); g++;
        end
        chk("ovf_sticky", overflow, 1);
        chk("ovf_count_two", ovf_count, OVFC_EXP);
        chk("full_valid", out_valid, 1);

        // Full buffer, consumer accepts in the strobe cycle: push accepted
        g = 0;
        while (!m_strobe() && g < 50) begin step(); g++; end
        out_ready = 1'b1;
        step();
        chk("full_pop_push_ovf_count", ovf_count, OVFC_EXP);
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) nv++;
            step();
        end
        chk("occupancy_kept_4", nv, 4);

        // Three entries, stop -> drain without strobes, then pop out
        out_ready = 1'b0;
        n = 0; g = 0;
        while (n < 3 && g < 100) begin
            if (m_strobe()) n++;
            step(); g++;
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        ns = 0;
        for (int i = 0; i < 30; i++) begin
            if (ds_strobe) ns++;
            step();
        end
        chk("drain_no_strobe", ns, 0);
        chk("drain_busy", busy, 1);
        out_ready = 1'b1;
        np = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid) np++;
            step();
        end
        chk("drain_pops", np, 3);
        chk("drain_idle_busy", busy, 0);
        chk("drain_empty", out_valid, 0);

        // Reset in RUN with two entries, then a full warmup again
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        g = 0;
        while (m_q.size() < 2 && g < 300) begin step(); g++; end
        chk("two_entries_valid", out_valid, 1);
        do_reset();
        measure_start("run2");

        // Stop in RUN, then stop during WARMUP
        stop = 1'b1;
        step();
        stop = 1'b0;
        g = 0;
        while (m_phase != 0 && g < 20) begin step(); g++; end
        chk("stop_run_idle", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 30; i++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_warmup_idle", busy, 0);

        // Random traffic against the model
        idx_mode = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 59) == 0);
            out_ready = (i < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            sample_in = OW'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hybrid_run_ctrl.md
HYBRID_RUN_CTRL -- requirements
Module: hybrid_run_ctrl

Interface
REQ-001 SHALL have parameter DSR, default 12: downsample ratio, i.e. fast clk cycles per filter output sample (>=2).
REQ-002 SHALL have parameter WARMUP, default 8: number of downsampled strobes discarded after start while the filter pipeline fills (>=1).
REQ-003 SHALL have parameter OUT_WIDTH, default 14: filter result width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries (power of two, >=2).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: run request, sampled in IDLE only.
REQ-008 SHALL have port stop, input, 1 bit: halt request, sampled in WARMUP/RUN only.
REQ-009 SHALL have port ds_strobe, output, 1 bit: one-cycle pulse driving the filter's downsampled stage.
REQ-010 SHALL have port sample_in, input, OUT_WIDTH bits: filter result, valid in the ds_strobe cycle.
REQ-011 SHALL have port out_data, output, OUT_WIDTH bits: FIFO head.
REQ-012 SHALL have port out_valid, output, 1 bit: FIFO not empty.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accept; pop when out_valid&&out_ready.
REQ-014 SHALL have port busy, output, 1 bit: state != IDLE.
REQ-015 SHALL have port overflow, output, 1 bit: sticky, set when a RUN sample was dropped.
REQ-016 SHALL have port ovf_count, output, 8 bits: dropped-sample count (see Configuration).

Function
REQ-017 SHALL implement states IDLE, WARMUP, RUN, DRAIN, with registered state.
REQ-018 IDLE: divider counter held at 0, ds_strobe=0; start=1 -> WARMUP, clears overflow and ovf_count.
REQ-019 In WARMUP and RUN, the divider SHALL count 0..DSR-1 and wrap; ds_strobe=1 exactly in cycles where count==DSR-1, so the first strobe occurs DSR cycles after entering WARMUP.
REQ-020 WARMUP: SHALL count strobes; sample_in ignored; on the WARMUP-th strobe -> RUN (that strobe's sample is discarded).
REQ-021 RUN: each strobe SHALL push sample_in into the FIFO; out_valid rises the cycle after the push into an empty FIFO.
REQ-022 Push SHALL be accepted if FIFO not full, or if full and a pop occurs in the same cycle; otherwise sample dropped and overflow set.
REQ-023 Pop and push in same cycle on non-full, non-empty FIFO SHALL leave occupancy unchanged; FIFO order strictly first-in-first-out with pointer wrap at FIFO_DEPTH.
REQ-024 stop=1 in WARMUP SHALL go to IDLE next cycle; FIFO untouched.
REQ-025 stop=1 in RUN SHALL go to DRAIN; a strobe in the same cycle is still pushed.
REQ-026 DRAIN: divider held at 0, no strobes; when FIFO empty (including the cycle the last entry pops) -> IDLE next cycle.
REQ-027 start outside IDLE and stop outside WARMUP/RUN SHALL be ignored; start and stop simultaneously in IDLE: start wins.
REQ-028 out_data SHALL hold the head entry stable while out_valid=1 and out_ready=0.

Reset
REQ-029 rst=0 SHALL asynchronously force: state IDLE, divider 0, warmup count 0, FIFO empty, ds_strobe=0, out_valid=0, out_data=0, busy=0, overflow=0, ovf_count=0.
REQ-030 Reset asserted mid-RUN/DRAIN SHALL discard FIFO contents; release resumes in IDLE awaiting start.

Configuration
REQ-031 Macro HYBRID_RUN_CTRL_OVFCNT_EN defined: ovf_count increments per dropped sample, saturating at 255, cleared on start and reset.
REQ-032 Macro undefined: no counter logic; ovf_count tied to 0; overflow flag unaffected.

Verification
REQ-033 DSR=12, WARMUP=8: start pulse at cycle 0 -> first ds_strobe cycle 12, strobes every 12 cycles, RUN entered after strobe 8 (cycle 96), first push at cycle 108, out_valid=1 at cycle 109.
REQ-034 out_ready=1 always, sample_in=strobe index -> out_data sequence 9,10,11,... each valid 1 cycle after its strobe, no overflow.
REQ-035 out_ready=0 for 6 RUN strobes, FIFO_DEPTH=4 -> 4 entries kept, 2 dropped, overflow=1, ovf_count=2 (macro on) / 0 (macro off); release ready -> first 4 samples out in order.
REQ-036 FIFO full, out_ready=1 in strobe cycle -> push accepted, no overflow, occupancy stays 4.
REQ-037 stop in RUN with 3 entries, out_ready=0 -> DRAIN, no strobes; ready=1 -> 3 pops, IDLE one cycle after last pop, busy=0.
REQ-038 rst=0 asserted mid-RUN with 2 entries -> out_valid=0 immediately; after release, start -> full warmup repeats per REQ-033.
